// File: rtl/udcnt_pkg.sv
// udcnt_pkg: shared definitions for the parametrised up/down counter.
//   ud_e       direction encoding seen on the u_d input (UD_UP / UD_DOWN)
//   MODE_WRAP  SATURATE value selecting wrap-around at the range ends
//   MODE_SAT   SATURATE value selecting hold at the range ends
//   clamp_ld   maps a load value into 0..modulo-1 (values past the top become modulo-1)
package udcnt_pkg;

  typedef enum logic {
    UD_DOWN = 1'b0,
    UD_UP   = 1'b1
  } ud_e;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // 64-bit operands so that MODULO == 2**32 is representable.
  function automatic logic [63:0] clamp_ld(input logic [63:0] d, input logic [63:0] modulo);
    return (d < modulo) ? d : (modulo - 64'd1);
  endfunction

endpackage

// File: rtl/udcnt_next.sv
// udcnt_next: combinational next-count and range-end detection.
//   q       current count
//   u_d     direction (1 = up, 0 = down)
//   next_q  count after one enabled step, honouring wrap/saturate mode
//   at_top  q == MODULO-1
//   at_bot  q == 0
module udcnt_next
  import udcnt_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MODULO   = 16,
  parameter int unsigned      SATURATE = 0
) (
  input  logic [WIDTH-1:0] q,
  input  logic             u_d,
  output logic [WIDTH-1:0] next_q,
  output logic             at_top,
  output logic             at_bot
);

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULO - 64'd1);
  localparam bit               IS_SAT = (SATURATE == MODE_SAT);

  logic [WIDTH:0] q_w;
  logic [WIDTH:0] nxt_w;

  assign q_w    = {1'b0, q};
  assign at_top = (q == MAX_Q);
  assign at_bot = (q == '0);

  // One guard bit keeps q+1 exact when MODULO == 2**WIDTH.
  always_comb begin
    nxt_w = q_w;
    if (u_d == UD_UP) begin
      if (at_top) nxt_w = IS_SAT ? q_w : '0;
      else        nxt_w = q_w + (WIDTH+1)'(1);
    end else begin
      if (at_bot) nxt_w = IS_SAT ? q_w : {1'b0, MAX_Q};
      else        nxt_w = q_w - (WIDTH+1)'(1);
    end
  end

  assign next_q = WIDTH'(nxt_w);

endmodule

// File: rtl/udcnt_mod.sv
// udcnt_mod: parametrised up/down counter with load, wrap/saturate mode,
// terminal count and sticky overflow/underflow flags.
//   clk  system clock, all state on rising edge
//   rst  synchronous active-high reset (highest priority)
//   en   count enable, one step per enabled clock
//   u_d  direction: 1 = up, 0 = down
//   ld   synchronous parallel load (overrides en)
//   d    load value, clamped to MODULO-1
//   q    registered count
//   tc   combinational terminal count for the current direction, gated by en
//   ovf  sticky flag, set on an up-step from MODULO-1
//   unf  sticky flag, set on a down-step from 0
module udcnt_mod
  import udcnt_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MODULO   = 16,
  parameter int unsigned      SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             u_d,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] step_q;
  logic             at_top, at_bot;

  udcnt_next #(
    .WIDTH    (WIDTH),
    .MODULO   (MODULO),
    .SATURATE (SATURATE)
  ) u_next (
    .q      (q_q),
    .u_d    (u_d),
    .next_q (step_q),
    .at_top (at_top),
    .at_bot (at_bot)
  );

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (ld) begin
      q_d   = WIDTH'(clamp_ld(64'(d), 64'(MODULO)));
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (en) begin
      q_d = step_q;
      if ((u_d == UD_UP) && at_top)   ovf_d = 1'b1;
      if ((u_d == UD_DOWN) && at_bot) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;
  assign unf = unf_q;
  assign tc  = en & ((u_d & at_top) | (~u_d & at_bot));

endmodule

// File: tb/tb_udcnt_mod.sv
module tb_udcnt_mod;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, u_d = 1'b0, ld = 1'b0;
  logic [7:0] d   = '0;

  logic [3:0] q_a, q_b, q_c;
  logic [7:0] q_e;
  logic [3:0] tc_v, ovf_v, unf_v;

  always #5 clk = ~clk;

  // 0: W4/M16/wrap  1: W4/M10/wrap  2: W4/M10/sat  3: W8/M256/wrap
  udcnt_mod #(.WIDTH(4), .MODULO(16), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .u_d(u_d), .ld(ld), .d(d[3:0]),
    .q(q_a), .tc(tc_v[0]), .ovf(ovf_v[0]), .unf(unf_v[0]));
  udcnt_mod #(.WIDTH(4), .MODULO(10), .SATURATE(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .u_d(u_d), .ld(ld), .d(d[3:0]),
    .q(q_b), .tc(tc_v[1]), .ovf(ovf_v[1]), .unf(unf_v[1]));
  udcnt_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .u_d(u_d), .ld(ld), .d(d[3:0]),
    .q(q_c), .tc(tc_v[2]), .ovf(ovf_v[2]), .unf(unf_v[2]));
  udcnt_mod #(.WIDTH(8), .MODULO(256), .SATURATE(0)) u_e (
    .clk(clk), .rst(rst), .en(en), .u_d(u_d), .ld(ld), .d(d),
    .q(q_e), .tc(tc_v[3]), .ovf(ovf_v[3]), .unf(unf_v[3]));

  typedef struct packed {
    logic [3:0][7:0] q;
    logic [3:0]      tc;
    logic [3:0]      ovf;
    logic [3:0]      unf;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: plain integer arithmetic per configuration.
  int mods[4]  = '{16, 10, 10, 256};
  int sats[4]  = '{0, 0, 1, 0};
  int masks[4] = '{15, 15, 15, 255};
  int mq[4];
  bit mo[4];
  bit mu[4];
  bit mvalid = 1'b0;

  task automatic check(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[dut%0d] cyc=%0d got=%0d expected=%0d", name, i, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit l, input bit e, input bit u, input logic [7:0] dv);
    exp_t ent;
    int dd;
    @(negedge clk);
    rst = r; ld = l; en = e; u_d = u; d = dv;
    cyc++;
    if (mvalid) begin
      for (int i = 0; i < 4; i++) begin
        ent.q[i]   = 8'(mq[i]);
        ent.ovf[i] = mo[i];
        ent.unf[i] = mu[i];
        ent.tc[i]  = e && ((u && mq[i] == mods[i] - 1) || (!u && mq[i] == 0));
      end
      sb.push_back(ent);
    end
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        mq[i] = 0; mo[i] = 0; mu[i] = 0;
      end else if (l) begin
        dd    = int'(dv) & masks[i];
        mq[i] = (dd < mods[i]) ? dd : mods[i] - 1;
        mo[i] = 0; mu[i] = 0;
      end else if (e) begin
        if (u) begin
          if (mq[i] + 1 >= mods[i]) mo[i] = 1;
          mq[i] = sats[i] != 0 ? ((mq[i] + 1 < mods[i]) ? mq[i] + 1 : mods[i] - 1)
                               : (mq[i] + 1) % mods[i];
        end else begin
          if (mq[i] == 0) mu[i] = 1;
          mq[i] = sats[i] != 0 ? ((mq[i] > 0) ? mq[i] - 1 : 0)
                               : (mq[i] + mods[i] - 1) % mods[i];
        end
      end
    end
    if (r) mvalid = 1'b1;
  endtask

  // Monitor: the counter presents a result every cycle; compare once inputs settle.
  initial begin
    exp_t ent;
    int   aq[4];
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        ent   = sb.pop_front();
        aq[0] = int'(q_a); aq[1] = int'(q_b); aq[2] = int'(q_c); aq[3] = int'(q_e);
        for (int i = 0; i < 4; i++) begin
          check("q",   i, aq[i],             int'(ent.q[i]));
          check("tc",  i, int'(tc_v[i]),     int'(ent.tc[i]));
          check("ovf", i, int'(ovf_v[i]),    int'(ent.ovf[i]));
          check("unf", i, int'(unf_v[i]),    int'(ent.unf[i]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset then count up 20 clocks.
    step(1, 0, 0, 1, 8'd0);
    for (int k = 0; k < 20; k++) step(0, 0, 1, 1, 8'd0);
    // Reset then count down from 0.
    step(1, 0, 0, 0, 8'd0);
    for (int k = 0; k < 12; k++) step(0, 0, 1, 0, 8'd0);
    // Load 8, up 4, down 12.
    step(0, 1, 0, 1, 8'd8);
    for (int k = 0; k < 4; k++)  step(0, 0, 1, 1, 8'd0);
    for (int k = 0; k < 12; k++) step(0, 0, 1, 0, 8'd0);
    // Load with en asserted and out-of-range value: clamps, no step, flags clear.
    step(0, 1, 1, 1, 8'd12);
    step(0, 0, 0, 1, 8'd0);
    // Count to 7 then reset together with load.
    step(0, 1, 0, 1, 8'd0);
    for (int k = 0; k < 7; k++) step(0, 0, 1, 1, 8'd0);
    step(1, 1, 1, 1, 8'd3);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 8'd0);
    // Full-range 8-bit wrap, then alternate direction each clock.
    step(0, 1, 0, 1, 8'd255);
    step(0, 0, 1, 1, 8'd0);
    for (int k = 0; k < 6; k++) step(0, 0, 1, k[0] == 1'b0 ? 1'b0 : 1'b1, 8'd0);
    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 7,
           1'($urandom),
           8'($urandom));
    end
    step(0, 0, 0, 0, 8'd0);
    @(negedge clk);
    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
